uart_tx_fifo: RTL



---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//  - uart_state_e : transmitter FSM state encodings
//  - UART_DATA_BITS : payload bits per frame (8N1)
//  - UART_IDLE_LVL  : line level while idle and during the stop bit
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO, 2**DEPTH_LOG2 entries, head visible combinationally.
// Ports:
//  clk_i, rst_i   clock, asynchronous active-high reset (flags/pointers only)
//  push_i, din_i  write request and data; ignored while full (even with a pop)
//  pop_i          read request; the head is dout_o in the same cycle
//  dout_o         current head entry
//  full_o         registered full flag
//  empty_o        occupancy is zero
//  level_o        occupancy, 0..2**DEPTH_LOG2
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] din_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [DEPTH_LOG2:0]       level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]       level_q, level_d;
  logic                      full_q;
  logic                      push_ok, pop_ok;

  // Acceptance looks only at the registered full flag, so a pop in the
  // same cycle never frees room for a push.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & (level_q != '0);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (DEPTH_LOG2+1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q <= level_d;
      full_q  <= (level_d == (DEPTH_LOG2+1)'(DEPTH));
    end
  end

  // Storage carries no reset; only pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO.
// Ports:
//  wb_clk_i, wb_rst_i  clock, asynchronous active-high reset
//  enable              1 = frames may start; 0 = finish current frame then idle
//  clk_div             clock cycles per bit, sampled at each frame start (0 acts as 1)
//  tx_data, tx_valid   byte enqueue; transfers when tx_valid & tx_ready
//  tx_ready            FIFO not full (registered)
//  ser_tx              serial line, idles high, driven straight from a flop
//  busy                frame in progress or FIFO not empty
//  fifo_level          FIFO occupancy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int DIV_W      = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic [7:0]          tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                ser_tx,
  output logic                busy,
  output logic [DEPTH_LOG2:0] fifo_level
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e         state_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [DIV_W-1:0]    bit_len_q;
  logic [DIV_W-1:0]    len_sel;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic [7:0]          head;
  logic                ser_q;
  logic                avail_q;
  logic                full, empty;
  logic                bit_done, start_frame;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (tx_valid),
    .din_i   (tx_data),
    .pop_i   (start_frame),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign len_sel  = eff_div(clk_div);
  assign bit_done = (cnt_q == '0);

  // From IDLE the start decision waits for a registered copy of "not empty",
  // giving a fixed two-cycle accept-to-start-bit latency. At the end of a
  // stop bit the live flag is used so queued frames follow with no gap.
  assign start_frame = enable & ~empty &
                       (((state_q == ST_IDLE) & avail_q) |
                        ((state_q == ST_STOP) & bit_done));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      ser_q     <= UART_IDLE_LVL;
      avail_q   <= 1'b0;
    end else begin
      avail_q <= ~empty;
      case (state_q)
        ST_IDLE: begin
          if (start_frame) begin
            state_q <= ST_START;
            cnt_q   <= len_sel - DIV_W'(1);
            ser_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_q   <= ST_DATA;
            bit_idx_q <= '0;
            cnt_q     <= bit_len_q - DIV_W'(1);
            ser_q     <= shift_q[0];
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            cnt_q <= bit_len_q - DIV_W'(1);
            if (bit_idx_q == LAST_BIT) begin
              state_q <= ST_STOP;
              ser_q   <= UART_IDLE_LVL;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              // shift_q moves right on this same edge; present its next LSB now
              ser_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (start_frame) begin
              state_q <= ST_START;
              cnt_q   <= len_sel - DIV_W'(1);
              ser_q   <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Frame payload and bit time are data; they are loaded on every frame start.
  always_ff @(posedge wb_clk_i) begin
    if (start_frame) begin
      shift_q   <= head;
      bit_len_q <= len_sel;
    end else if ((state_q == ST_DATA) && bit_done) begin
      shift_q <= shift_q >> 1;
    end
  end

  assign tx_ready = ~full;
  assign ser_tx   = ser_q;
  assign busy     = (state_q != ST_IDLE) | (fifo_level != '0);

endmodule
